// File: rtl/muldiv_pkg.sv
// Shared opcode encodings, FSM states and opcode classifiers for the
// iterative M-extension multiply/divide unit.
package muldiv_pkg;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    function automatic logic is_div(input logic [2:0] f);
        return f[2];
    endfunction

    function automatic logic is_rem(input logic [2:0] f);
        return (f == OP_REM) || (f == OP_REMU);
    endfunction

    function automatic logic is_quot(input logic [2:0] f);
        return (f == OP_DIV) || (f == OP_DIVU);
    endfunction

    // High-half multiplies; plain MUL takes the low half.
    function automatic logic is_mulh(input logic [2:0] f);
        return !f[2] && (f != OP_MUL);
    endfunction

    function automatic logic signed_a(input logic [2:0] f);
        return (f == OP_MULH) || (f == OP_MULHSU) || (f == OP_DIV) || (f == OP_REM);
    endfunction

    function automatic logic signed_b(input logic [2:0] f);
        return (f == OP_MULH) || (f == OP_DIV) || (f == OP_REM);
    endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// Conditional two's-complement negate of a double-width value followed by
// a low/high half select; serves both operand abs and result fix-up.
module muldiv_sign_fix #(
    parameter int unsigned XLEN = 32
) (
    input  logic [2*XLEN-1:0] val_i,
    input  logic              neg_i,
    input  logic              hi_i,
    output logic [XLEN-1:0]   res_c_o
);

    localparam int unsigned W2 = 2 * XLEN;

    logic [W2-1:0] fixed_c;

    always_comb begin
        fixed_c = neg_i ? (~val_i + W2'(1)) : val_i;
        res_c_o = hi_i ? fixed_c[W2-1:XLEN] : fixed_c[XLEN-1:0];
    end

endmodule

// File: rtl/muldiv_iter_unit.sv
// Multi-cycle RV32M/RV64M multiply/divide unit: radix-2 shift-add multiply
// and restoring divide sharing one double-width accumulator.
module muldiv_iter_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned EARLY_OUT = 1,
    parameter int unsigned CNT_W     = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    localparam int unsigned W2 = 2 * XLEN;
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_e            state_q;
    logic [2:0]        op_q;
    logic [XLEN-1:0]   b_q;
    logic [W2-1:0]     acc_q, acc_d;
    logic              a_neg_q, b_neg_q, special_q;
    logic [XLEN-1:0]   special_res_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              in_ready_q, out_valid_q, busy_q;
    logic [XLEN-1:0]   result_q;

    logic              a_neg_c, b_neg_c, div_zero_c, ovf_c;
    logic [XLEN-1:0]   abs_a_c, abs_b_c, special_res_c, fix_res_c;
    logic [W2-1:0]     fix_val_c;
    logic              fix_neg_c;
    logic [XLEN:0]     mul_sum_c, div_trial_c, div_diff_c;

    // Accept-time operand classification, abs values and special results.
    always_comb begin
        a_neg_c    = signed_a(funct3) && op_a[XLEN-1];
        b_neg_c    = signed_b(funct3) && op_b[XLEN-1];
        div_zero_c = is_div(funct3) && (op_b == '0);
        ovf_c      = ((funct3 == OP_DIV) || (funct3 == OP_REM))
                     && (op_a == MIN_NEG) && (op_b == '1);
        if (div_zero_c) begin
            special_res_c = is_quot(funct3) ? '1 : op_a;
        end else begin
            special_res_c = is_quot(funct3) ? op_a : '0;
        end
    end

    muldiv_sign_fix #(.XLEN(XLEN)) u_abs_a (
        .val_i   ({{XLEN{1'b0}}, op_a}),
        .neg_i   (a_neg_c),
        .hi_i    (1'b0),
        .res_c_o (abs_a_c)
    );

    muldiv_sign_fix #(.XLEN(XLEN)) u_abs_b (
        .val_i   ({{XLEN{1'b0}}, op_b}),
        .neg_i   (b_neg_c),
        .hi_i    (1'b0),
        .res_c_o (abs_b_c)
    );

    // One radix-2 step; divide keeps {remainder, quotient} in the accumulator.
    always_comb begin
        acc_d       = acc_q;
        mul_sum_c   = '0;
        div_trial_c = '0;
        div_diff_c  = '0;
        if (is_div(op_q)) begin
            div_trial_c = acc_q[W2-1:XLEN-1];
            div_diff_c  = div_trial_c - {1'b0, b_q};
            if (div_trial_c >= {1'b0, b_q}) begin
                acc_d = {div_diff_c[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
            end else begin
                acc_d = {div_trial_c[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
            end
        end else begin
            mul_sum_c = {1'b0, acc_q[W2-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
            acc_d     = {mul_sum_c, acc_q[XLEN-1:1]};
        end
    end

    always_comb begin
        if (!is_div(op_q)) begin
            fix_val_c = acc_q;
        end else if (is_rem(op_q)) begin
            fix_val_c = {{XLEN{1'b0}}, acc_q[W2-1:XLEN]};
        end else begin
            fix_val_c = {{XLEN{1'b0}}, acc_q[XLEN-1:0]};
        end
        fix_neg_c = is_rem(op_q) ? a_neg_q : (a_neg_q ^ b_neg_q);
    end

    muldiv_sign_fix #(.XLEN(XLEN)) u_fix (
        .val_i   (fix_val_c),
        .neg_i   (fix_neg_c),
        .hi_i    (is_mulh(op_q)),
        .res_c_o (fix_res_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            op_q          <= OP_MUL;
            b_q           <= '0;
            acc_q         <= '0;
            a_neg_q       <= 1'b0;
            b_neg_q       <= 1'b0;
            special_q     <= 1'b0;
            special_res_q <= '0;
            cnt_q         <= '0;
            in_ready_q    <= 1'b1;
            out_valid_q   <= 1'b0;
            busy_q        <= 1'b0;
            result_q      <= '0;
        end else if (flush) begin
            state_q     <= S_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        op_q          <= funct3;
                        b_q           <= abs_b_c;
                        acc_q         <= {{XLEN{1'b0}}, abs_a_c};
                        a_neg_q       <= a_neg_c;
                        b_neg_q       <= b_neg_c;
                        special_q     <= div_zero_c || ovf_c;
                        special_res_q <= special_res_c;
                        cnt_q         <= '0;
                        in_ready_q    <= 1'b0;
                        busy_q        <= 1'b1;
                        // Special cases skip iteration; FIX publishes the precomputed value.
                        state_q       <= ((EARLY_OUT != 0) && (div_zero_c || ovf_c))
                                         ? S_FIX : S_CALC;
                    end
                end
                S_CALC: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(XLEN - 1)) begin
                        state_q <= S_FIX;
                    end
                end
                S_FIX: begin
                    result_q    <= special_q ? special_res_q : fix_res_c;
                    out_valid_q <= 1'b1;
                    state_q     <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign result    = result_q;

endmodule

// File: tb/tb_muldiv_iter_unit.sv
// Self-checking bench: two instances (EARLY_OUT=1 and 0) share stimulus and
// are compared against arithmetic reference results.
module tb_muldiv_iter_unit;

    localparam int unsigned NORM_LAT = 33;

    logic        clk = 1'b0;
    logic        rst, in_valid, flush, out_ready;
    logic [2:0]  funct3;
    logic [31:0] op_a, op_b;

    logic        in_ready1, out_valid1, busy1;
    logic [31:0] result1;
    logic        in_ready0, out_valid0, busy0;
    logic [31:0] result0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    muldiv_iter_unit #(.XLEN(32), .EARLY_OUT(1)) dut_e1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
        .funct3(funct3), .op_a(op_a), .op_b(op_b), .flush(flush),
        .out_valid(out_valid1), .out_ready(out_ready), .result(result1), .busy(busy1)
    );

    muldiv_iter_unit #(.XLEN(32), .EARLY_OUT(0)) dut_e0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
        .funct3(funct3), .op_a(op_a), .op_b(op_b), .flush(flush),
        .out_valid(out_valid0), .out_ready(out_ready), .result(result0), .busy(busy0)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference: RISC-V M semantics via 64-bit arithmetic.
    function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a,
                                              input logic [31:0] b);
        longint      sa, sb, ps;
        logic [63:0] ua, ub, pu;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (f)
            3'd0: begin ps = sa * sb; return ps[31:0]; end
            3'd1: begin ps = sa * sb; return ps[63:32]; end
            3'd2: begin ps = sa * longint'(ub); return ps[63:32]; end
            3'd3: begin pu = ua * ub; return pu[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                ps = sa / sb;
                return ps[31:0];
            end
            3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                ps = sa % sb;
                return ps[31:0];
            end
            default: return (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    function automatic logic is_special(input logic [2:0] f, input logic [31:0] a,
                                        input logic [31:0] b);
        if (f[2] && b == 32'd0) return 1'b1;
        return (f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Issue one op with out_ready=1; check value, latency and busy on both units.
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input string tag);
        bit          got1, got0, busy_ok;
        int          lat1, lat0;
        logic [31:0] res1, res0;
        got1 = 0; got0 = 0; busy_ok = 1; lat1 = 0; lat0 = 0; res1 = '0; res0 = '0;
        funct3 = f; op_a = a; op_b = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (!busy0) busy_ok = 0;
        for (int c = 1; c <= 40 && !(got1 && got0); c++) begin
            @(posedge clk); #1;
            if (!got1 && out_valid1) begin got1 = 1; lat1 = c; res1 = result1; end
            if (!got0 && out_valid0) begin got0 = 1; lat0 = c; res0 = result0; end
            if (!got0 && !busy0) busy_ok = 0;
        end
        check({tag, " e1 result"}, res1, exp);
        check({tag, " e1 latency"}, 32'(lat1), is_special(f, a, b) ? 32'd1 : 32'(NORM_LAT));
        check({tag, " e0 result"}, res0, exp);
        check({tag, " e0 latency"}, 32'(lat0), 32'(NORM_LAT));
        check({tag, " e0 busy held"}, 32'(busy_ok), 32'd1);
        @(posedge clk); #1;
        check({tag, " back idle"}, {26'd0, in_ready1, out_valid1, busy1, in_ready0, out_valid0, busy0},
              32'b100100);
    endtask

    logic [2:0]  t_f[12]   = '{3'd0, 3'd3, 3'd1, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd5, 3'd7, 3'd4, 3'd6};
    logic [31:0] t_a[12]   = '{32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9,
                               32'hFFFF_FFF9, 32'd100, 32'd100, 32'd100, 32'd100,
                               32'h8000_0000, 32'h8000_0000};
    logic [31:0] t_b[12]   = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2,
                               32'd2, 32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] t_exp[12] = '{32'hFFFF_FFEB, 32'hFFFF_FFFE, 32'h0000_0000, 32'hFFFF_FFFF,
                               32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2, 32'hFFFF_FFFF,
                               32'd100, 32'h8000_0000, 32'd0};

    initial begin
        bit          got;
        logic [2:0]  rf;
        logic [31:0] ra, rb;

        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        funct3 = 3'd0; op_a = '0; op_b = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset e1 ctl", {29'd0, in_ready1, out_valid1, busy1}, 32'b100);
        check("reset e1 result", result1, 32'd0);
        check("reset e0 ctl", {29'd0, in_ready0, out_valid0, busy0}, 32'b100);
        check("reset e0 result", result0, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 12; i++) begin
            run_op(t_f[i], t_a[i], t_b[i], t_exp[i], $sformatf("dir%0d", i));
        end

        for (int i = 0; i < 40; i++) begin
            rf = 3'($urandom_range(0, 7));
            ra = pick_operand();
            rb = pick_operand();
            run_op(rf, ra, rb, ref_model(rf, ra, rb), $sformatf("rnd%0d f%0d", i, rf));
        end

        // Flush a DIV in its tenth iteration cycle.
        funct3 = 3'd4; op_a = 32'd1000; op_b = 32'd3; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush e1 ctl", {29'd0, in_ready1, out_valid1, busy1}, 32'b100);
        check("flush e0 ctl", {29'd0, in_ready0, out_valid0, busy0}, 32'b100);
        run_op(3'd0, 32'd3, 32'd5, 32'd15, "post-flush mul");

        // Backpressure: result held in DONE while a new request is ignored.
        out_ready = 1'b0;
        funct3 = 3'd5; op_a = 32'd100; op_b = 32'd7; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        got = 0;
        for (int c = 0; c < 40 && !got; c++) begin
            @(posedge clk); #1;
            if (out_valid1 && out_valid0) got = 1;
        end
        check("bp arrive", 32'(got), 32'd1);
        funct3 = 3'd0; op_a = 32'd9; op_b = 32'd9; in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check($sformatf("bp hold e1 cyc%0d", k), {result1[28:0], in_ready1, out_valid1, busy1},
                  {29'd14, 3'b011});
            check($sformatf("bp hold e0 cyc%0d", k), {result0[28:0], in_ready0, out_valid0, busy0},
                  {29'd14, 3'b011});
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp release e1", {29'd0, in_ready1, out_valid1, busy1}, 32'b100);
        check("bp release e0", {29'd0, in_ready0, out_valid0, busy0}, 32'b100);

        // Reset mid-iteration clears everything including the held result.
        funct3 = 3'd0; op_a = 32'd1234; op_b = 32'd5678; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mid rst e1 ctl", {29'd0, in_ready1, out_valid1, busy1}, 32'b100);
        check("mid rst e1 result", result1, 32'd0);
        check("mid rst e0 ctl", {29'd0, in_ready0, out_valid0, busy0}, 32'b100);
        check("mid rst e0 result", result0, 32'd0);
        run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, "post-rst mulh");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
